fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decoder. It holds the PC and issues one 32-bit instruction read at a time to the instruction memory port. Returned instructions are buffered in a small FIFO, together with their PCs, and presented to the decoder over a valid/ready handshake. A redirect input (branch/jump from a later stage) flushes the FIFO and restarts fetch at a new PC.

Parameters:
RESET_PC, 64'h0, PC loaded on reset
XLEN, 64, PC/address width
QDEPTH, 2, instruction FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  restart fetch at redirect_pc this cycle
redirect_pc  in  XLEN  new fetch PC, 4-byte aligned
mem_req_valid  out  1  read request valid
mem_req_addr  out  XLEN  read address (current PC)
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  read data valid
mem_resp_data  in  32  instruction word
dec_valid  out  1  FIFO head valid to decoder
dec_instr  out  32  FIFO head instruction
dec_pc  out  XLEN  FIFO head PC
dec_ready  in  1  decoder consumes head

Behaviour:
- Reset (sync, active-high): pc=RESET_PC, FIFO empty, state=REQ, outstanding=0. While reset is high, all outputs are 0.
- Request handshake: a request transfers when mem_req_valid && mem_req_ready. Only one request is outstanding at a time.
- mem_req_valid = (state==REQ) && (count + outstanding < QDEPTH) && !redirect_valid.
- mem_req_addr = pc.
- FSM:
  - REQ: on handshake, pc <= pc+4 (mod 2^XLEN), go to WAIT.
  - WAIT: on mem_resp_valid, push {pc_of_req, mem_resp_data} into the FIFO and go to REQ.
  - DROP: on mem_resp_valid, discard the data and go to REQ.
- The PC of the in-flight request is held in a register (req_pc) captured at the handshake.
- Decoder side: dec_valid = (count != 0). dec_instr/dec_pc are the FIFO head. The head pops when dec_valid && dec_ready.
- Push and pop can occur in the same cycle; count is unchanged.
- Request gating reserves a FIFO slot for the outstanding response, so a push never sees a full FIFO.
- Minimum spacing: a request in cycle N allows a response in N+1, a push visible at dec_valid in N+2, and the next request in N+2.
- After reset deasserts, mem_req_valid rises in the first cycle, with addr=RESET_PC.
- Redirect (highest priority; evaluated every cycle):
  - FIFO is flushed (count=0, no pop takes effect).
  - pc <= redirect_pc.
  - If state==WAIT, next state is DROP. If state==DROP, it stays DROP, unless mem_resp_valid arrives this cycle, in which case the next state is REQ.
  - If state==REQ, no request is issued this cycle, since mem_req_valid is forced low; stay in REQ.
  - A response arriving in the same cycle as a redirect is discarded.
- Redirect while FIFO is full or empty: same behaviour, flush.
- mem_resp_valid while state==REQ (no outstanding request) is a protocol error: ignore it, and an assertion fires.
- redirect_pc[1:0] != 0: the redirect is still taken, and an assertion fires. Alignment is the producer's responsibility.
- Reset mid-operation, including with a request outstanding: return to reset state. Any later stale response arrives in REQ and is ignored, with no push. The memory port is reset in the same cycle.

Decomposition:
- Package riscv_pkg holds:
  - XLEN and ILEN=32 constants
  - fetch_state_e enum {REQ, WAIT, DROP}
  - fetch_entry_t struct {logic [XLEN-1:0] pc; logic [31:0] instr;}
  - The same package later carries the decoder's opcode constants.
- One sub-module: fetch_queue. It is a synchronous FIFO of fetch_entry_t with parameter DEPTH, push/pop/flush inputs, and count/head outputs. Flush has priority over push and pop.

Test Plan:
1. Reset with RESET_PC=0x1000, memory always ready, 1-cycle response, dec_ready=1 -> mem_req_addr sequence 0x1000, 0x1004, 0x1008 every 2 cycles; dec_pc/dec_instr match in order.
2. dec_ready=0, memory always ready -> exactly 2 requests issued (0x1000, 0x1004). mem_req_valid then stays low, count=2, no overflow. Raise dec_ready -> fetch resumes at 0x1008.
3. Redirect to 0x2000 while in WAIT (request 0x1008 outstanding), response arrives next cycle -> response dropped, FIFO empty, next request addr=0x2000, first decoded pc=0x2000.
4. redirect_valid and mem_resp_valid in the same cycle with the FIFO holding 1 entry -> FIFO count=0, no push, next request addr=redirect_pc.
5. mem_req_ready held low 5 cycles -> mem_req_valid and addr stable at 0x1000, pc not incremented. Then ready=1 -> one handshake, pc=0x1004.
6. Reset asserted with a request outstanding, stale response delivered 1 cycle after reset release -> ignored, dec_valid stays 0, first request addr=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: widths, fetch FSM states and the fetch queue entry.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries. Flush beats push and pop.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop) && !i_flush;

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry storage; contents of empty slots are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding 32-bit read, results queued for the decoder,
// redirect flushes the queue and restarts fetch. XLEN must match riscv_pkg::XLEN.
module fetch_unit #(
  parameter int unsigned    XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  output logic            dec_valid,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);

  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;

  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic            w_outstanding;
  logic            w_room;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;

  // A slot is reserved for the in-flight response so a push never finds the queue full.
  assign w_outstanding = (r_state == WAIT);
  assign w_room        = (32'(w_count) + 32'(w_outstanding)) < QDEPTH;

  assign w_req_fire = mem_req_valid && mem_req_ready;
  assign w_push     = !reset && (r_state == WAIT) && mem_resp_valid && !redirect_valid;
  assign w_pop      = dec_valid && dec_ready && !redirect_valid;

  assign w_push_entry.pc    = r_req_pc;
  assign w_push_entry.instr = mem_resp_data;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state. A response landing in WAIT always closes the read, even under a
  // redirect (the data is discarded by the push gating); otherwise a redirect turns the
  // pending read into one that must be drained.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      REQ:     if (w_req_fire) w_state_next = WAIT;
      WAIT: begin
        if (mem_resp_valid) begin
          w_state_next = REQ;
        end else if (redirect_valid) begin
          w_state_next = DROP;
        end
      end
      DROP:    if (mem_resp_valid) w_state_next = REQ;
      default: w_state_next = REQ;
    endcase
  end

  // FSM outputs; everything is held at zero while reset is asserted.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    dec_valid     = 1'b0;
    dec_instr     = '0;
    dec_pc        = '0;
    if (!reset) begin
      mem_req_valid = (r_state == REQ) && w_room && !redirect_valid;
      mem_req_addr  = r_pc;
      dec_valid     = (w_count != '0);
      dec_instr     = w_head.instr;
      dec_pc        = w_head.pc;
    end
  end

  // Fetch PC and the PC of the read currently in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_req_fire) begin
        r_pc <= r_pc + XLEN'(4);
      end
      if (w_req_fire) r_req_pc <= r_pc;
    end
  end

`ifndef SYNTHESIS
  // Stray responses are tolerated in hardware but flagged in simulation.
  a_resp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(mem_resp_valid && (r_state == REQ)))
    else $warning("fetch_unit: response with no read in flight was ignored");

  a_redirect_aligned: assert property (@(posedge clk) disable iff (reset)
    !(redirect_valid && (redirect_pc[1:0] != 2'b00)))
    else $warning("fetch_unit: misaligned redirect_pc taken");
`endif

endmodule
